// File: rtl/layer_sequencer.sv
// Layer sequencer: walks every neuron of one fully-connected layer through
// clear, operand streaming, MAC drain, activation and result handoff.
module layer_sequencer #(
    parameter int unsigned N_INPUTS  = 8,
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned MAC_LAT   = 2,
    parameter int unsigned IDX_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             out_ready,
    output logic             ag_rst,
    output logic             ag_read,
    output logic             alu_rst,
    output logic             alu_acc,
    output logic             act_en,
    output logic             out_valid,
    output logic [IDX_W-1:0] neuron_idx,
    output logic [IDX_W-1:0] input_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [IDX_W-1:0]   INPUT_LAST  = IDX_W'(N_INPUTS - 1);
    localparam logic [IDX_W-1:0]   NEURON_LAST = IDX_W'(N_NEURONS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_ACT   = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   neuron_d, input_d;
    logic [DRAIN_W-1:0] drain_cnt, drain_d;

    logic ag_rst_d, ag_read_d, alu_rst_d, alu_acc_d;
    logic act_en_d, out_valid_d, busy_d, done_d;

    // Next-state and counter update; abort overrides every normal transition.
    always_comb begin
        state_d  = state;
        neuron_d = neuron_idx;
        input_d  = input_idx;
        drain_d  = drain_cnt;

        case (state)
            S_IDLE: begin
                neuron_d = '0;
                input_d  = '0;
                drain_d  = '0;
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                input_d = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (input_idx == INPUT_LAST) begin
                    input_d = '0;
                    drain_d = '0;
                    state_d = (MAC_LAT > 0) ? S_DRAIN : S_ACT;
                end else begin
                    input_d = input_idx + IDX_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = S_ACT;
                end else begin
                    drain_d = drain_cnt + DRAIN_W'(1);
                end
            end
            S_ACT: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (out_ready) begin
                    if (neuron_idx == NEURON_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        neuron_d = neuron_idx + IDX_W'(1);
                        state_d  = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                neuron_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                neuron_d = '0;
                input_d  = '0;
                drain_d  = '0;
                state_d  = S_IDLE;
            end
        endcase

        if (abort && (state != S_IDLE)) begin
            state_d  = S_IDLE;
            neuron_d = '0;
            input_d  = '0;
            drain_d  = '0;
        end
    end

    // Strobe decode of the upcoming state, so the strobes register alongside it.
    always_comb begin
        ag_rst_d    = 1'b0;
        ag_read_d   = 1'b0;
        alu_rst_d   = 1'b0;
        alu_acc_d   = 1'b0;
        act_en_d    = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
        done_d      = 1'b0;

        case (state_d)
            S_IDLE: begin
                ag_rst_d  = 1'b1;
                alu_rst_d = 1'b1;
                busy_d    = 1'b0;
            end
            S_CLEAR: begin
                ag_rst_d  = 1'b1;
                alu_rst_d = 1'b1;
            end
            S_ACCUM: begin
                ag_read_d = 1'b1;
                alu_acc_d = 1'b1;
            end
            S_ACT:   act_en_d    = 1'b1;
            S_WRITE: out_valid_d = 1'b1;
            S_DONE:  done_d      = 1'b1;
            default: ;
        endcase
    end

    // State, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            neuron_idx <= '0;
            input_idx  <= '0;
            drain_cnt  <= '0;
            ag_rst     <= 1'b1;
            ag_read    <= 1'b0;
            alu_rst    <= 1'b1;
            alu_acc    <= 1'b0;
            act_en     <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            neuron_idx <= neuron_d;
            input_idx  <= input_d;
            drain_cnt  <= drain_d;
            ag_rst     <= ag_rst_d;
            ag_read    <= ag_read_d;
            alu_rst    <= alu_rst_d;
            alu_acc    <= alu_acc_d;
            act_en     <= act_en_d;
            out_valid  <= out_valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a 4x2 layer with MAC_LAT=2 and a
// degenerate 1x1 layer with MAC_LAT=0, checked cycle by cycle.
module tb_layer_sequencer;

    // Flag byte order: ag_rst ag_read alu_rst alu_acc act_en out_valid busy done
    localparam logic [7:0] F_IDLE  = 8'hA0;
    localparam logic [7:0] F_CLEAR = 8'hA2;
    localparam logic [7:0] F_ACCUM = 8'h52;
    localparam logic [7:0] F_DRAIN = 8'h02;
    localparam logic [7:0] F_ACT   = 8'h0A;
    localparam logic [7:0] F_WRITE = 8'h06;
    localparam logic [7:0] F_DONE  = 8'h03;

    logic clk = 1'b0;
    logic reset;

    logic       start_a, abort_a, out_ready_a;
    logic       ag_rst_a, ag_read_a, alu_rst_a, alu_acc_a, act_en_a, out_valid_a, busy_a, done_a;
    logic [7:0] neuron_idx_a, input_idx_a;

    logic       start_e, abort_e, out_ready_e;
    logic       ag_rst_e, ag_read_e, alu_rst_e, alu_acc_e, act_en_e, out_valid_e, busy_e, done_e;
    logic [7:0] neuron_idx_e, input_idx_e;

    logic [23:0] obs_a, obs_e;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.N_INPUTS(4), .N_NEURONS(2), .MAC_LAT(2), .IDX_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .out_ready(out_ready_a),
        .ag_rst(ag_rst_a), .ag_read(ag_read_a), .alu_rst(alu_rst_a), .alu_acc(alu_acc_a),
        .act_en(act_en_a), .out_valid(out_valid_a), .neuron_idx(neuron_idx_a),
        .input_idx(input_idx_a), .busy(busy_a), .done(done_a)
    );

    layer_sequencer #(.N_INPUTS(1), .N_NEURONS(1), .MAC_LAT(0), .IDX_W(8)) dut_e (
        .clk(clk), .reset(reset), .start(start_e), .abort(abort_e), .out_ready(out_ready_e),
        .ag_rst(ag_rst_e), .ag_read(ag_read_e), .alu_rst(alu_rst_e), .alu_acc(alu_acc_e),
        .act_en(act_en_e), .out_valid(out_valid_e), .neuron_idx(neuron_idx_e),
        .input_idx(input_idx_e), .busy(busy_e), .done(done_e)
    );

    assign obs_a = {ag_rst_a, ag_read_a, alu_rst_a, alu_acc_a, act_en_a, out_valid_a, busy_a, done_a,
                    neuron_idx_a, input_idx_a};
    assign obs_e = {ag_rst_e, ag_read_e, alu_rst_e, alu_acc_e, act_en_e, out_valid_e, busy_e, done_e,
                    neuron_idx_e, input_idx_e};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] observed, input logic [23:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %06h expected %06h", tag, observed, expected);
        end
    endtask

    // Hand-derived schedule for the 4-input, 2-neuron, MAC_LAT=2 layer with start
    // sampled in cycle 0; w extra WRITE cycles are spent stalled on neuron 0.
    function automatic logic [23:0] exp_a(input int c, input int w);
        int b;
        b = 10 + w;
        if (c <= 0)      return {F_IDLE,  8'd0, 8'd0};
        if (c == 1)      return {F_CLEAR, 8'd0, 8'd0};
        if (c <= 5)      return {F_ACCUM, 8'd0, 8'(c - 2)};
        if (c <= 7)      return {F_DRAIN, 8'd0, 8'd0};
        if (c == 8)      return {F_ACT,   8'd0, 8'd0};
        if (c <= 9 + w)  return {F_WRITE, 8'd0, 8'd0};
        if (c == b)      return {F_CLEAR, 8'd1, 8'd0};
        if (c <= b + 4)  return {F_ACCUM, 8'd1, 8'(c - b - 1)};
        if (c <= b + 6)  return {F_DRAIN, 8'd1, 8'd0};
        if (c == b + 7)  return {F_ACT,   8'd1, 8'd0};
        if (c == b + 8)  return {F_WRITE, 8'd1, 8'd0};
        if (c == b + 9)  return {F_DONE,  8'd1, 8'd0};
        return {F_IDLE, 8'd0, 8'd0};
    endfunction

    // Drive and check the wide instance for cycles 0..last; start is also
    // re-pulsed at cycle 3 while busy, out_ready is low for w cycles from 9.
    task automatic run_a(input string name, input int w, input int last, input int abort_c);
        for (int c = 0; c <= last; c++) begin
            chk($sformatf("%s_c%0d", name, c), obs_a, exp_a(c, w));
            start_a     = (c == 0) || (c == 3);
            out_ready_a = !((c >= 9) && (c < 9 + w));
            abort_a     = (c == abort_c);
            step();
        end
        start_a     = 1'b0;
        abort_a     = 1'b0;
        out_ready_a = 1'b1;
    endtask

    initial begin
        logic [23:0] exp_edge [0:12];

        reset       = 1'b1;
        start_a     = 1'b0;
        abort_a     = 1'b0;
        out_ready_a = 1'b1;
        start_e     = 1'b0;
        abort_e     = 1'b0;
        out_ready_e = 1'b1;

        // Reset state, with start asserted to show it is ignored under reset
        step();
        start_a = 1'b1;
        step();
        chk("rst_a", obs_a, {F_IDLE, 8'd0, 8'd0});
        chk("rst_e", obs_e, {F_IDLE, 8'd0, 8'd0});
        start_a = 1'b0;
        reset   = 1'b0;
        step();
        chk("post_rst_a", obs_a, {F_IDLE, 8'd0, 8'd0});

        // Basic timing, then backpressure of 5 cycles on neuron 0
        run_a("basic", 0, 21, -1);
        run_a("bp", 5, 26, -1);

        // Abort while input_idx==2
        run_a("abort_acc", 0, 4, 4);
        chk("abort_acc_idle", obs_a, {F_IDLE, 8'd0, 8'd0});
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("abort_acc_hold%0d", k), obs_a, {F_IDLE, 8'd0, 8'd0});
        end
        run_a("restart", 0, 21, -1);

        // Reset while neuron 1 is in WRITE
        run_a("rst_wr", 0, 17, -1);
        chk("rst_wr_write", obs_a, {F_WRITE, 8'd1, 8'd0});
        out_ready_a = 1'b0;
        reset       = 1'b1;
        start_a     = 1'b1;
        step();
        chk("rst_wr_reset", obs_a, {F_IDLE, 8'd0, 8'd0});
        step();
        chk("rst_wr_start_ign", obs_a, {F_IDLE, 8'd0, 8'd0});
        reset   = 1'b0;
        start_a = 1'b0;
        out_ready_a = 1'b1;
        step();
        chk("rst_wr_after", obs_a, {F_IDLE, 8'd0, 8'd0});

        // Abort together with the last neuron's transfer: no done pulse
        run_a("abort_wr", 0, 18, 18);
        chk("abort_wr_idle", obs_a, {F_IDLE, 8'd0, 8'd0});
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("abort_wr_nodone%0d", k), obs_a, {F_IDLE, 8'd0, 8'd0});
        end

        // Degenerate layer: start held high through DONE re-launches from IDLE
        exp_edge[0]  = {F_IDLE,  8'd0, 8'd0};
        exp_edge[1]  = {F_CLEAR, 8'd0, 8'd0};
        exp_edge[2]  = {F_ACCUM, 8'd0, 8'd0};
        exp_edge[3]  = {F_ACT,   8'd0, 8'd0};
        exp_edge[4]  = {F_WRITE, 8'd0, 8'd0};
        exp_edge[5]  = {F_DONE,  8'd0, 8'd0};
        exp_edge[6]  = {F_IDLE,  8'd0, 8'd0};
        exp_edge[7]  = {F_CLEAR, 8'd0, 8'd0};
        exp_edge[8]  = {F_ACCUM, 8'd0, 8'd0};
        exp_edge[9]  = {F_ACT,   8'd0, 8'd0};
        exp_edge[10] = {F_WRITE, 8'd0, 8'd0};
        exp_edge[11] = {F_DONE,  8'd0, 8'd0};
        exp_edge[12] = {F_IDLE,  8'd0, 8'd0};
        for (int c = 0; c <= 12; c++) begin
            chk($sformatf("edge_c%0d", c), obs_e, exp_edge[c]);
            start_e = (c <= 6);
            step();
        end
        start_e = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
